blink_input_loader: RTL and testbench

BLINK_INPUT_LOADER -- requirements
Module: blink_input_loader

---
 rtl/blink_input_loader_pkg.sv | 35 +++
 rtl/blink_input_loader.sv | 185 ++++++++++++++++++
 tb/tb_blink_input_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/blink_input_loader_pkg.sv
// Shared constants and enumerations for the Blink operand loader.
// Field widths, word counts per field and frame lengths live here so the
// loader and anything that consumes its outputs agree on the layout.
package blink_input_loader_pkg;

    localparam int K0_W = 448;
    localparam int K1_W = 382;
    localparam int T_W  = 128;
    localparam int P_W  = 64;

    localparam int K0_WORDS = 14;
    localparam int K1_WORDS = 12;
    localparam int T_WORDS  = 4;
    localparam int P_WORDS  = 2;

    localparam int FULL_WORDS  = K0_WORDS + K1_WORDS + T_WORDS + P_WORDS;
    localparam int SHORT_WORDS = T_WORDS + P_WORDS;

    localparam logic [4:0] FULL_LAST  = 5'(FULL_WORDS - 1);
    localparam logic [4:0] SHORT_LAST = 5'(SHORT_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FLD_K0 = 2'd0,
        FLD_K1 = 2'd1,
        FLD_T  = 2'd2,
        FLD_P  = 2'd3
    } field_t;

endpackage

// File: rtl/blink_input_loader.sv
// Serial-to-parallel operand loader sitting in front of the Blink core.
// Collects a 32-word full frame (K0, K1, T, P) or a 6-word short frame
// (T, P only, reusing the previously loaded key) and presents the operand
// set with a valid/ready handshake.
module blink_input_loader
    import blink_input_loader_pkg::*;
#(
    parameter int WORD_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_key,
    input  logic              in_enc,
    output logic              in_ready,
    output logic [K0_W-1:0]   K0,
    output logic [K1_W-1:0]   K1,
    output logic [T_W-1:0]    T,
    output logic [P_W-1:0]    P,
    output logic              enc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    state_t     state;
    state_t     state_n;
    logic [4:0] cnt;        // index of the next word while in LOAD
    logic       frame_key;  // frame type latched from the first word
    logic       key_ok;     // a full frame has loaded K0/K1 since reset

    logic       accept;
    logic [4:0] widx;
    logic       fkey;
    logic       last;
    logic       frame_done;
    logic       deliver;
    field_t     fld;
    logic [3:0] sub;

    assign in_ready   = (state != HOLD);
    assign accept     = in_valid && in_ready;
    assign frame_done = accept && last;
    // A short frame can only be delivered if a key is already present.
    assign deliver    = frame_done && (fkey || key_ok);

    // Word index and frame type of the word currently on in_data; the first
    // word of a frame uses the live in_key since nothing is latched yet.
    always_comb begin
        widx = (state == IDLE) ? 5'd0 : cnt;
        fkey = (state == IDLE) ? in_key : frame_key;
        last = (widx == (fkey ? FULL_LAST : SHORT_LAST));
    end

    // Map the frame word index onto a destination field and a word slot.
    always_comb begin
        fld = FLD_P;
        sub = 4'd0;
        if (fkey) begin
            if (widx < 5'(K0_WORDS)) begin
                fld = FLD_K0;
                sub = widx[3:0];
            end else if (widx < 5'(K0_WORDS + K1_WORDS)) begin
                fld = FLD_K1;
                sub = 4'(widx - 5'(K0_WORDS));
            end else if (widx < 5'(K0_WORDS + K1_WORDS + T_WORDS)) begin
                fld = FLD_T;
                sub = 4'(widx - 5'(K0_WORDS + K1_WORDS));
            end else begin
                fld = FLD_P;
                sub = 4'(widx - 5'(K0_WORDS + K1_WORDS + T_WORDS));
            end
        end else begin
            if (widx < 5'(T_WORDS)) begin
                fld = FLD_T;
                sub = widx[3:0];
            end else begin
                fld = FLD_P;
                sub = 4'(widx - 5'(T_WORDS));
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: IDLE -> LOAD on first word, LOAD -> HOLD (or back to
    // IDLE for an undeliverable short frame) on last word, HOLD -> IDLE on
    // the output handshake.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (frame_done) begin
                    state_n = deliver ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control registers: word counter, frame attributes, key status,
    // output valid and the missing-key error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= 5'd0;
            frame_key <= 1'b0;
            key_ok    <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            enc       <= 1'b0;
        end else begin
            err <= frame_done && !fkey && !key_ok;
            if (accept) begin
                cnt <= widx + 5'd1;
            end
            if (accept && (state == IDLE)) begin
                frame_key <= in_key;
                enc       <= in_enc;
            end
            if (frame_done && fkey) begin
                key_ok <= 1'b1;
            end
            if (deliver) begin
                out_valid <= 1'b1;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Operand registers: each accepted word lands in its field slot, least
    // significant word first; K1's top word only carries 30 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            K0 <= '0;
            K1 <= '0;
            T  <= '0;
            P  <= '0;
        end else if (accept) begin
            case (fld)
                FLD_K0: begin
                    for (int i = 0; i < K0_WORDS; i++) begin
                        if (sub == 4'(i)) K0[32*i +: 32] <= in_data;
                    end
                end
                FLD_K1: begin
                    for (int i = 0; i < K1_WORDS - 1; i++) begin
                        if (sub == 4'(i)) K1[32*i +: 32] <= in_data;
                    end
                    if (sub == 4'(K1_WORDS - 1)) K1[K1_W-1 -: 30] <= in_data[29:0];
                end
                FLD_T: begin
                    for (int i = 0; i < T_WORDS; i++) begin
                        if (sub == 4'(i)) T[32*i +: 32] <= in_data;
                    end
                end
                default: begin
                    for (int i = 0; i < P_WORDS; i++) begin
                        if (sub == 4'(i)) P[32*i +: 32] <= in_data;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_input_loader.sv
// Testbench for blink_input_loader: directed frames plus randomized frames
// and gaps, checked against a frame-level reference model.
module tb_blink_input_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_key = 1'b0;
    logic         in_enc = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic [447:0] K0;
    logic [381:0] K1;
    logic [127:0] T;
    logic [63:0]  P;
    logic         enc;
    logic         out_valid;
    logic         err;

    blink_input_loader #(.WORD_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_key    (in_key),
        .in_enc    (in_enc),
        .in_ready  (in_ready),
        .K0        (K0),
        .K1        (K1),
        .T         (T),
        .P         (P),
        .enc       (enc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: the operand set the core should see.
    logic [447:0] m_k0;
    logic [381:0] m_k1;
    logic [127:0] m_t;
    logic [63:0]  m_p;
    logic         m_enc;
    logic         m_key_ok;
    logic [31:0]  frame[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [447:0] obs, input logic [447:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        m_k0 = '0; m_k1 = '0; m_t = '0; m_p = '0; m_enc = 1'b0; m_key_ok = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic k, input logic e);
        int budget;
        budget = 0;
        in_data = w; in_key = k; in_enc = e; in_valid = 1'b1;
        while (in_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $error("FAIL send_timeout: in_ready %b required 1", in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_data = $urandom;
        in_key = 1'($urandom);
        in_enc = 1'($urandom);
    endtask

    // Sends the words in 'frame'; frame attributes are only meaningful on the
    // first word, later words carry random in_key/in_enc.
    task automatic send_frame(input logic key, input logic e, input int gapmax);
        int gap;
        for (int i = 0; i < frame.size(); i++) begin
            if (i > 0 && gapmax > 0) begin
                gap = $urandom_range(gapmax, 0);
                for (int g = 0; g < gap; g++) tick();
            end
            if (i == 0) send_word(frame[i], key, e);
            else        send_word(frame[i], 1'($urandom), 1'($urandom));
        end
    endtask

    // Expected operand set from frame contents, per field layout.
    task automatic model_frame(input logic key, input logic e);
        int tb;
        tb = 0;
        if (key) begin
            m_k0 = '0;
            m_k1 = '0;
            for (int i = 0; i < 14; i++) m_k0 = m_k0 | (448'(frame[i]) << (32 * i));
            for (int j = 0; j < 12; j++) m_k1 = m_k1 | (382'(frame[14 + j]) << (32 * j));
            tb = 26;
            m_key_ok = 1'b1;
        end
        m_t = '0;
        m_p = '0;
        for (int i = 0; i < 4; i++) m_t = m_t | (128'(frame[tb + i]) << (32 * i));
        for (int i = 0; i < 2; i++) m_p = m_p | (64'(frame[tb + 4 + i]) << (32 * i));
        m_enc = e;
    endtask

    task automatic check_delivered(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_K0"}, K0, m_k0);
        check({tag, "_K1"}, K1, m_k1);
        check({tag, "_T"}, T, m_t);
        check({tag, "_P"}, P, m_p);
        check({tag, "_enc"}, enc, m_enc);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_hs_out_valid"}, out_valid, 1'b0);
        check({tag, "_hs_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic check_err_pulse(input string tag);
        check({tag, "_err_hi"}, err, 1'b1);
        check({tag, "_ov_lo"}, out_valid, 1'b0);
        check({tag, "_rdy"}, in_ready, 1'b1);
        tick();
        check({tag, "_err_lo"}, err, 1'b0);
        check({tag, "_ov_lo2"}, out_valid, 1'b0);
        check({tag, "_rdy2"}, in_ready, 1'b1);
    endtask

    task automatic build_directed_full();
        frame.delete();
        for (int i = 0; i < 14; i++) frame.push_back(32'h1000 + 32'(i));
        for (int j = 0; j < 12; j++) frame.push_back(32'h2000 + 32'(j));
        frame.push_back(32'hA); frame.push_back(32'hB);
        frame.push_back(32'hC); frame.push_back(32'hD);
        frame.push_back(32'h11); frame.push_back(32'h22);
    endtask

    initial begin
        logic key;
        logic e;
        logic deliverable;
        int nwords;
        int holdc;

        // Reset state.
        do_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_K0", K0, '0);
        check("rst_K1", K1, '0);
        check("rst_T", T, '0);
        check("rst_P", P, '0);
        check("rst_enc", enc, 1'b0);

        // Short frame with no key loaded: consumed, err pulse, no delivery.
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back($urandom);
        send_frame(1'b0, 1'b1, 0);
        check_err_pulse("nokey");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nokey_quiet_err", err, 1'b0);
            check("nokey_quiet_ov", out_valid, 1'b0);
        end

        // Directed full frame.
        build_directed_full();
        send_frame(1'b1, 1'b1, 0);
        model_frame(1'b1, 1'b1);
        check_delivered("full");
        check("full_P_const", P, 64'h00000022_00000011);
        check("full_K1_top", K1[381:352], 30'h0000200B);

        // Stall in HOLD with the next frame's first word already offered.
        in_valid = 1'b1; in_key = 1'b0; in_enc = 1'b0; in_data = 32'h5;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_K0", K0, m_k0);
            check("hold_T", T, m_t);
            check("hold_P", P, m_p);
        end
        handshake("hold");

        // Short frame reusing the key: first word was held across HOLD.
        frame.delete();
        frame.push_back(32'h5); frame.push_back(32'h6);
        frame.push_back(32'h7); frame.push_back(32'h8);
        frame.push_back(32'h33); frame.push_back(32'h44);
        send_frame(1'b0, 1'b0, 0);
        model_frame(1'b0, 1'b0);
        check_delivered("short");
        check("short_T_const", T, 128'h00000008_00000007_00000006_00000005);
        handshake("short");

        // Directed full frame again with random gaps between words.
        build_directed_full();
        send_frame(1'b1, 1'b1, 3);
        model_frame(1'b1, 1'b1);
        check_delivered("gapfull");
        check("gapfull_P_const", P, 64'h00000022_00000011);
        handshake("gapfull");

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            key = 1'($urandom);
            e = 1'($urandom);
            nwords = key ? 32 : 6;
            frame.delete();
            for (int i = 0; i < nwords; i++) frame.push_back($urandom);
            deliverable = key || m_key_ok;
            send_frame(key, e, 2);
            if (deliverable) begin
                model_frame(key, e);
                check_delivered("rand");
                holdc = $urandom_range(3, 0);
                for (int c = 0; c < holdc; c++) tick();
                check("rand_held_K1", K1, m_k1);
                handshake("rand");
            end else begin
                check_err_pulse("rand_nokey");
            end
        end

        // Reset partway through a full frame discards the key.
        build_directed_full();
        for (int i = 0; i < 18; i++) send_word(frame[i], (i == 0) ? 1'b1 : 1'($urandom), 1'b1);
        do_reset();
        check("midrst_K0", K0, '0);
        check("midrst_ov", out_valid, 1'b0);
        check("midrst_rdy", in_ready, 1'b1);
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back($urandom);
        send_frame(1'b0, 1'b0, 1);
        check_err_pulse("midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
